// File: rtl/i2s2_tx.sv
// i2s2_tx: FIFO-fed mono I2S transmitter; derives MCLK/SCLK/LRCK from one counter.
// Define I2S2_TX_UFCNT_EN to add uf_cnt, a saturating count of underflow pulses.
module i2s2_tx #(
    parameter int CNT_W  = 11,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [DATA_W-1:0] fifo_dout,
    input  logic              fifo_empty,
    output logic              fifo_rd,
    output logic              mclk,
    output logic              sclk,
    output logic              lrck,
    output logic              sdout,
    output logic              underflow
`ifdef I2S2_TX_UFCNT_EN
    ,
    output logic [15:0]       uf_cnt
`endif
);

    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [DATA_W-1:0] sample_reg;
    logic [DATA_W-1:0] rev;
    logic [31:0]       slot_bits;
    logic [4:0]        slot_nxt;
    logic              frame_end;
    logic              sd_nxt;

    assign cnt_nxt   = cnt + 1'b1;
    assign frame_end = en && (cnt == '1);
    assign fifo_rd   = rst_n && frame_end && !fifo_empty;
    assign underflow = rst_n && frame_end && fifo_empty;

    assign mclk = cnt[CNT_W-9];
    assign sclk = cnt[CNT_W-7];
    assign lrck = cnt[CNT_W-1];

    // slot_bits[k] = sample_reg[DATA_W-k] for k = 1..DATA_W, zero elsewhere,
    // so the one-slot I2S delay and MSB-first order fall out of a single index.
    assign rev       = {<<{sample_reg}};
    assign slot_bits = 32'({rev, 1'b0});
    assign slot_nxt  = cnt_nxt[CNT_W-2 -: 5];
    assign sd_nxt    = slot_bits[slot_nxt];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt        <= '0;
            sample_reg <= '0;
            sdout      <= 1'b0;
        end else if (!en) begin
            cnt   <= '0;
            sdout <= 1'b0;
        end else begin
            cnt   <= cnt_nxt;
            sdout <= sd_nxt;
            if (frame_end) begin
                sample_reg <= fifo_empty ? '0 : fifo_dout;
            end
        end
    end

`ifdef I2S2_TX_UFCNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            uf_cnt <= '0;
        end else if (underflow && (uf_cnt != 16'hFFFF)) begin
            uf_cnt <= uf_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_i2s2_tx.sv
// tb_i2s2_tx: directed bench for i2s2_tx with a behavioural FIFO and a cycle model.
module tb_i2s2_tx;

    localparam int CNT_W  = 11;
    localparam int DATA_W = 16;
    localparam int FRAME  = 2048;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        fifo_empty = 1'b1;
    logic [15:0] fifo_dout = '0;
    logic        fifo_rd, mclk, sclk, lrck, sdout, underflow;
`ifdef I2S2_TX_UFCNT_EN
    logic [15:0] uf_cnt;
`endif

    always #5 clk = ~clk;

    i2s2_tx #(
        .CNT_W (CNT_W),
        .DATA_W(DATA_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .fifo_dout (fifo_dout),
        .fifo_empty(fifo_empty),
        .fifo_rd   (fifo_rd),
        .mclk      (mclk),
        .sclk      (sclk),
        .lrck      (lrck),
        .sdout     (sdout),
        .underflow (underflow)
`ifdef I2S2_TX_UFCNT_EN
        ,
        .uf_cnt    (uf_cnt)
`endif
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // FIFO contents and reference state
    logic [15:0] fq[$];
    logic [15:0] msample = '0;
    logic [15:0] rx[$];
    logic [15:0] cap = '0;
    int          mcnt = 0;
    int          cyc = 0;
    int          pop_cyc[$];
    int          pop_mcnt[$];
    logic        pop_now;
    logic        chk_on = 1'b0;

    int uf_pulses = 0, ones = 0, zero_bad = 0;
    int mclk_r = 0, sclk_r = 0, lrck_t = 0, lrck_bad = 0;
    logic mclk_q = 1'b0, sclk_q = 1'b0, lrck_q = 1'b0;

    always begin
        @(posedge clk);
        pop_now = fifo_rd;
        cyc++;
        if (pop_now) begin
            pop_cyc.push_back(cyc);
            pop_mcnt.push_back(mcnt);
        end
        if (!rst_n) begin
            mcnt    = 0;
            msample = '0;
        end else if (!en) begin
            mcnt = 0;
        end else begin
            if (mcnt == FRAME - 1) msample = fifo_empty ? 16'h0 : fifo_dout;
            mcnt = (mcnt + 1) % FRAME;
        end
        #1;
        if (pop_now && fq.size() > 0) void'(fq.pop_front());
        fifo_empty = (fq.size() == 0);
        fifo_dout  = fifo_empty ? 16'h0 : fq[0];
    end

    always @(negedge clk) begin
        int          slot;
        logic [15:0] sh;
        logic        exp_sd, exp_rd, exp_uf;
        if (chk_on) begin
            slot   = (mcnt % 1024) / 32;
            sh     = msample >> (16 - slot);
            exp_sd = (slot >= 1 && slot <= 16) ? sh[0] : 1'b0;
            exp_rd = rst_n && en && (mcnt == FRAME - 1) && !fifo_empty;
            exp_uf = rst_n && en && (mcnt == FRAME - 1) && fifo_empty;
            check("pins", 32'({mclk, sclk, lrck, sdout, fifo_rd, underflow}),
                  32'({((mcnt >> 2) & 1) == 1, ((mcnt >> 4) & 1) == 1,
                       ((mcnt >> 10) & 1) == 1, exp_sd, exp_rd, exp_uf}));
            if (underflow) uf_pulses++;
            if (sdout) ones++;
            if (sdout && !(slot >= 1 && slot <= 16)) zero_bad++;
            if (mclk && !mclk_q) mclk_r++;
            if (sclk && !sclk_q) sclk_r++;
            if (lrck != lrck_q) begin
                lrck_t++;
                if (!(sclk_q && !sclk)) lrck_bad++;
            end
            if (mcnt % 32 == 16 && slot >= 1 && slot <= 16) begin
                cap = {cap[14:0], sdout};
                if (slot == 16) rx.push_back(cap);
            end
        end
        mclk_q = mclk;
        sclk_q = sclk;
        lrck_q = lrck;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_cnt(input int v);
        int b = 0;
        while (mcnt != v && b < 5000) begin
            step(1);
            b++;
        end
        check("sync", 32'(mcnt), 32'(v));
    endtask

    task automatic clear_stats();
        uf_pulses = 0; ones = 0; zero_bad = 0;
        mclk_r = 0; sclk_r = 0; lrck_t = 0; lrck_bad = 0;
        rx.delete();
        pop_cyc.delete();
        pop_mcnt.delete();
    endtask

    logic [15:0] exp_rx[11];

    initial begin
        step(3);
        chk_on = 1'b1;

        // 1: reset mid-frame with a nonzero sample loaded
        rst_n = 1'b1;
        en    = 1'b1;
        fq.push_back(16'h1234);
        wait_cnt(FRAME - 1);
        wait_cnt(1500);
        check("pre_rst", 32'({mclk, sclk, lrck, sdout}), 32'h0000_000F);
        rst_n = 1'b0;
        step(1);
        check("rst_outs", 32'({mclk, sclk, lrck, sdout, fifo_rd, underflow}), 32'h0);
        step(3);
        check("rst_hold", 32'({mclk, sclk, lrck, sdout, fifo_rd, underflow}), 32'h0);
        clear_stats();
        rst_n = 1'b1;
        step(600);
        check("rst_words", 32'(rx.size()), 32'd1);
        if (rx.size() > 0) check("rst_sample", 32'(rx[0]), 32'h0);

        // 2: clock periods over one full frame, FIFO holding A5C3
        wait_cnt(0);
        fq.push_back(16'hA5C3);
        clear_stats();
        step(FRAME);
        check("mclk_rises", 32'(mclk_r), 32'd256);
        check("sclk_rises", 32'(sclk_r), 32'd64);
        check("lrck_toggles", 32'(lrck_t), 32'd2);
        check("lrck_on_sclk_fall", 32'(lrck_bad), 32'd0);
        check("clk_uf", 32'(uf_pulses), 32'd0);
        check("clk_pops", 32'(pop_cyc.size()), 32'd1);
        if (pop_mcnt.size() > 0) check("pop_at", 32'(pop_mcnt[0]), 32'd2047);

        // 3: A5C3 serialised on both halves
        clear_stats();
        step(FRAME);
        check("ser_words", 32'(rx.size()), 32'd2);
        if (rx.size() > 1) begin
            check("ser_left", 32'(rx[0]), 32'hA5C3);
            check("ser_right", 32'(rx[1]), 32'hA5C3);
        end
        check("ser_idle_slots", 32'(zero_bad), 32'd0);
        check("ser_pops", 32'(pop_cyc.size()), 32'd0);

        // 4: three empty frames
        clear_stats();
        step(3 * FRAME);
        check("uf_pulses", 32'(uf_pulses), 32'd3);
        check("uf_pops", 32'(pop_cyc.size()), 32'd0);
        check("uf_mute", 32'(ones), 32'd0);
`ifdef I2S2_TX_UFCNT_EN
        // underflows since reset release: one before test 2, one after test 3, three here
        check("uf_cnt", 32'(uf_cnt), 32'd5);
`endif

        // 5: four-sample stream then mute
        clear_stats();
        fq.push_back(16'h8001);
        fq.push_back(16'h7FFE);
        fq.push_back(16'hFFFF);
        fq.push_back(16'h0F0F);
        exp_rx = '{16'h0, 16'h0, 16'h8001, 16'h8001, 16'h7FFE, 16'h7FFE,
                   16'hFFFF, 16'hFFFF, 16'h0F0F, 16'h0F0F, 16'h0};
        step(5 * FRAME + 600);
        check("stream_pops", 32'(pop_cyc.size()), 32'd4);
        if (pop_cyc.size() == 4) begin
            for (int i = 1; i < 4; i++) check("pop_spacing", 32'(pop_cyc[i] - pop_cyc[i-1]), 32'd2048);
            for (int i = 0; i < 4; i++) check("stream_pop_at", 32'(pop_mcnt[i]), 32'd2047);
        end
        check("stream_uf", 32'(uf_pulses), 32'd1);
        check("stream_words", 32'(rx.size()), 32'd11);
        if (rx.size() == 11) begin
            for (int i = 0; i < 11; i++) check("stream_word", 32'(rx[i]), 32'(exp_rx[i]));
        end

        // 6: en dropped at cnt=700 for 10 clocks
        fq.push_back(16'h3C5A);
        wait_cnt(FRAME - 1);
        wait_cnt(700);
        clear_stats();
        en = 1'b0;
        step(1);
        check("en_off_outs", 32'({mclk, sclk, lrck, sdout, fifo_rd, underflow}), 32'h0);
        step(9);
        check("en_off_pops", 32'(pop_cyc.size()), 32'd0);
        check("en_off_ones", 32'(ones), 32'd0);
        en = 1'b1;
        step(600);
        check("en_words", 32'(rx.size()), 32'd1);
        if (rx.size() > 0) check("en_resume_sample", 32'(rx[0]), 32'h3C5A);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
